// File: rtl/td4_pkg.sv
// Shared types and constants for the TD4 program loader and run controller.
package td4_pkg;

    localparam int unsigned STATE_W     = 3;
    localparam int unsigned OPCODE_W    = 4;
    localparam int unsigned IMM_W       = 4;
    localparam int unsigned PROG_ADDR_W = 4;
    localparam int unsigned PROG_DEPTH  = 2 ** PROG_ADDR_W;
    localparam int unsigned STEP_CNT_W  = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_HALT = 3'd2,
        ST_RUN  = 3'd3,
        ST_STEP = 3'd4
    } run_state_e;

    // One program byte as it arrives on the load stream.
    typedef struct packed {
        logic [IMM_W-1:0]    imm;
        logic [OPCODE_W-1:0] opcode;
    } load_byte_t;

endpackage

// File: rtl/td4_run_ctrl_if.sv
// Load stream, command, memory-write and CPU-control bundle for td4_run_ctrl.
// Breakpoint signals exist only when TD4_RUN_CTRL_BREAKPOINT_EN is defined.
interface td4_run_ctrl_if #(
    parameter int unsigned ADDR_W = td4_pkg::PROG_ADDR_W
);
    import td4_pkg::*;

    logic                 load_start;
    logic                 load_valid;
    logic [7:0]           load_data;
    logic                 load_ready;
    logic                 cmd_run;
    logic                 cmd_step;
    logic                 cmd_halt;
    logic [ADDR_W-1:0]    pc;
    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_addr;
    logic [OPCODE_W-1:0]  mem_opcode;
    logic [IMM_W-1:0]     mem_imm;
    logic                 cpu_en;
    logic                 cpu_rst_n;
    logic [STATE_W-1:0]   state;
`ifdef TD4_RUN_CTRL_BREAKPOINT_EN
    logic                 bp_set;
    logic [ADDR_W-1:0]    bp_addr;
    logic                 bp_hit;
`endif

    modport master (
        output load_start, load_valid, load_data, cmd_run, cmd_step, cmd_halt, pc,
        input  load_ready, mem_we, mem_addr, mem_opcode, mem_imm, cpu_en, cpu_rst_n, state
`ifdef TD4_RUN_CTRL_BREAKPOINT_EN
        , output bp_set, bp_addr
        , input  bp_hit
`endif
    );

    modport slave (
        input  load_start, load_valid, load_data, cmd_run, cmd_step, cmd_halt, pc,
        output load_ready, mem_we, mem_addr, mem_opcode, mem_imm, cpu_en, cpu_rst_n, state
`ifdef TD4_RUN_CTRL_BREAKPOINT_EN
        , input  bp_set, bp_addr
        , output bp_hit
`endif
    );

endinterface

// File: rtl/td4_load_addr_gen.sv
// Program-load address counter and registered memory write port.
module td4_load_addr_gen
    import td4_pkg::*;
#(
    parameter int unsigned ADDR_W = PROG_ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                accept,
    input  load_byte_t          data,
    output logic                last_accept_c,
    output logic                last_write_c,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [OPCODE_W-1:0] mem_opcode,
    output logic [IMM_W-1:0]    mem_imm
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic [ADDR_W-1:0] cnt_q;

    // Each accepted byte becomes a one-cycle write on the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_opcode <= '0;
            mem_imm    <= '0;
        end else begin
            mem_we <= accept;
            if (clear) begin
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q      <= cnt_q + ADDR_W'(1);
                mem_addr   <= cnt_q;
                mem_opcode <= data.opcode;
                mem_imm    <= data.imm;
            end
        end
    end

    assign last_accept_c = accept && (cnt_q == LAST_ADDR);
    assign last_write_c  = mem_we && (mem_addr == LAST_ADDR);

endmodule

// File: rtl/td4_run_ctrl.sv
// TD4 sequencer: loads program memory, then holds, runs or single-steps the CPU.
// Optional breakpoint support is enabled by defining TD4_RUN_CTRL_BREAKPOINT_EN.
module td4_run_ctrl
    import td4_pkg::*;
#(
    parameter int unsigned ADDR_W      = PROG_ADDR_W,
    parameter int unsigned STEP_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    td4_run_ctrl_if.slave bus
);

    localparam logic [STEP_CNT_W-1:0] STEP_INIT = STEP_CNT_W'(STEP_CYCLES);

    run_state_e             state_q, state_d;
    logic [STEP_CNT_W-1:0]  step_q, step_d;
    logic                   load_ready_q, load_ready_d;
    logic                   cpu_en_q, cpu_en_d;
    logic                   cpu_rst_n_q, cpu_rst_n_d;
    logic                   clear_c, accept_c, last_accept_c, last_write_c;
    logic                   mem_we;
    logic [ADDR_W-1:0]      mem_addr;
    logic [OPCODE_W-1:0]    mem_opcode;
    logic [IMM_W-1:0]       mem_imm;

`ifdef TD4_RUN_CTRL_BREAKPOINT_EN
    logic                   bp_armed_q, bp_armed_d;
    logic [ADDR_W-1:0]      bp_addr_q, bp_addr_d;
    logic                   bp_hit_q, bp_hit_d;
`else
    logic                   pc_unused_c;
    assign pc_unused_c = ^bus.pc;
`endif

    assign accept_c = (state_q == ST_LOAD) && load_ready_q && bus.load_valid;

    td4_load_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (clear_c),
        .accept        (accept_c),
        .data          (load_byte_t'(bus.load_data)),
        .last_accept_c (last_accept_c),
        .last_write_c  (last_write_c),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_opcode    (mem_opcode),
        .mem_imm       (mem_imm)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            step_q       <= '0;
            load_ready_q <= 1'b0;
            cpu_en_q     <= 1'b0;
            cpu_rst_n_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            load_ready_q <= load_ready_d;
            cpu_en_q     <= cpu_en_d;
            cpu_rst_n_q  <= cpu_rst_n_d;
        end
    end

`ifdef TD4_RUN_CTRL_BREAKPOINT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp_armed_q <= 1'b0;
            bp_addr_q  <= '0;
            bp_hit_q   <= 1'b0;
        end else begin
            bp_armed_q <= bp_armed_d;
            bp_addr_q  <= bp_addr_d;
            bp_hit_q   <= bp_hit_d;
        end
    end
`endif

    // Next state; command priority is load_start > cmd_halt > cmd_step > cmd_run.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        clear_c = 1'b0;
`ifdef TD4_RUN_CTRL_BREAKPOINT_EN
        bp_armed_d = bp_armed_q;
        bp_addr_d  = bp_addr_q;
        bp_hit_d   = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE, ST_HALT: begin
                if (bus.load_start) begin
                    state_d = ST_LOAD;
                    clear_c = 1'b1;
                end else if (bus.cmd_halt) begin
                    state_d = state_q;
                end else if (bus.cmd_step) begin
                    state_d = ST_STEP;
                    step_d  = STEP_INIT;
                end else if (bus.cmd_run) begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (last_write_c) state_d = ST_HALT;
            end
            ST_RUN: begin
                if (bus.load_start) begin
                    state_d = ST_LOAD;
                    clear_c = 1'b1;
                end else if (bus.cmd_halt) begin
                    state_d = ST_HALT;
`ifdef TD4_RUN_CTRL_BREAKPOINT_EN
                end else if (bp_armed_q && (bus.pc == bp_addr_q)) begin
                    state_d    = ST_HALT;
                    bp_hit_d   = 1'b1;
                    bp_armed_d = 1'b0;
`endif
                end
            end
            ST_STEP: begin
                if (bus.load_start) begin
                    state_d = ST_LOAD;
                    clear_c = 1'b1;
                    step_d  = '0;
                end else if (bus.cmd_halt || (step_q <= STEP_CNT_W'(1))) begin
                    state_d = ST_HALT;
                    step_d  = '0;
                end else begin
                    step_d = step_q - STEP_CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef TD4_RUN_CTRL_BREAKPOINT_EN
        if (bus.bp_set) begin
            bp_armed_d = 1'b1;
            bp_addr_d  = bus.bp_addr;
        end
`endif

        // The CPU stays in reset for the first HALT cycle after a load.
        load_ready_d = (state_d == ST_LOAD) && !last_accept_c;
        cpu_en_d     = (state_d == ST_RUN) || ((state_d == ST_STEP) && (step_d != '0));
        cpu_rst_n_d  = ((state_d == ST_HALT) || (state_d == ST_RUN) || (state_d == ST_STEP))
                       && (state_q != ST_LOAD);
    end

    assign bus.load_ready = load_ready_q;
    assign bus.cpu_en     = cpu_en_q;
    assign bus.cpu_rst_n  = cpu_rst_n_q;
    assign bus.state      = state_q;
    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_opcode = mem_opcode;
    assign bus.mem_imm    = mem_imm;
`ifdef TD4_RUN_CTRL_BREAKPOINT_EN
    assign bus.bp_hit     = bp_hit_q;
`endif

endmodule

// File: tb/tb_td4_run_ctrl.sv
// Directed bench for td4_run_ctrl: program loads, step/run/halt table, async reset mid-load.
module tb_td4_run_ctrl;
    import td4_pkg::*;

    localparam int unsigned ADDR_W      = PROG_ADDR_W;
    localparam int unsigned STEP_CYCLES = 3;
    localparam int          NVEC        = 18;

    typedef struct {
        logic       ls;
        logic       run;
        logic       step;
        logic       halt;
        run_state_e st;
        logic       en;
        logic       rstn;
        logic       rdy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int          total = 0;
    int          bad = 0;
    int          en_count = 0;
    int          sent;
    logic        acc;
    logic [11:0] wr_q[$];
    vec_t        vecs[NVEC];

    td4_run_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    td4_run_ctrl #(.ADDR_W(ADDR_W), .STEP_CYCLES(STEP_CYCLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_state"}, 32'(bus.state), 32'(ST_IDLE));
        check({pfx, "_we"}, 32'(bus.mem_we), 32'd0);
        check({pfx, "_addr"}, 32'(bus.mem_addr), 32'd0);
        check({pfx, "_opcode"}, 32'(bus.mem_opcode), 32'd0);
        check({pfx, "_imm"}, 32'(bus.mem_imm), 32'd0);
        check({pfx, "_ready"}, 32'(bus.load_ready), 32'd0);
        check({pfx, "_en"}, 32'(bus.cpu_en), 32'd0);
        check({pfx, "_rstn"}, 32'(bus.cpu_rst_n), 32'd0);
    endtask

    // Write log, enabled-cycle count and write-port exclusivity checks.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.cpu_en) en_count++;
            if (bus.mem_we) begin
                wr_q.push_back({bus.mem_addr, bus.mem_opcode, bus.mem_imm});
                check("we_with_en", 32'(bus.cpu_en), 32'd0);
                check("we_in_load", 32'(bus.state), 32'(ST_LOAD));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ls run step halt | state en rstn rdy, starting in HALT
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, ST_STEP, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, ST_STEP, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, ST_STEP, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, ST_HALT, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, ST_STEP, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, ST_STEP, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, ST_STEP, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, ST_HALT, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, ST_RUN,  1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, ST_RUN,  1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, ST_HALT, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, ST_HALT, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, ST_RUN,  1'b1, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, ST_HALT, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, ST_STEP, 1'b1, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, ST_HALT, 1'b0, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, ST_HALT, 1'b0, 1'b1, 1'b0};
        vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b0, ST_LOAD, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0;
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = 8'h00;
        bus.cmd_run    = 1'b0;
        bus.cmd_step   = 1'b0;
        bus.cmd_halt   = 1'b0;
        bus.pc         = '0;
`ifdef TD4_RUN_CTRL_BREAKPOINT_EN
        bus.bp_set  = 1'b0;
        bus.bp_addr = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_reset("por");
        rst_n = 1'b1;
        tick();

        // Back-to-back load of 0x00..0x0F
        en_count = 0;
        wr_q.delete();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        check("l1_enter_state", 32'(bus.state), 32'(ST_LOAD));
        check("l1_enter_rstn", 32'(bus.cpu_rst_n), 32'd0);
        for (int k = 0; k < int'(PROG_DEPTH); k++) begin
            check($sformatf("l1_ready%0d", k), 32'(bus.load_ready), 32'd1);
            bus.load_valid = 1'b1;
            bus.load_data  = 8'(k);
            tick();
        end
        bus.load_data = 8'hFF;
        check("l1_last_we", 32'(bus.mem_we), 32'd1);
        check("l1_last_addr", 32'(bus.mem_addr), 32'(PROG_DEPTH - 1));
        check("l1_last_ready", 32'(bus.load_ready), 32'd0);
        check("l1_last_state", 32'(bus.state), 32'(ST_LOAD));
        tick();
        bus.load_valid = 1'b0;
        check("l1_halt_state", 32'(bus.state), 32'(ST_HALT));
        check("l1_halt_rstn0", 32'(bus.cpu_rst_n), 32'd0);
        check("l1_halt_we", 32'(bus.mem_we), 32'd0);
        tick();
        check("l1_halt_rstn1", 32'(bus.cpu_rst_n), 32'd1);
        check("l1_halt_state2", 32'(bus.state), 32'(ST_HALT));
        check("l1_wr_count", 32'(wr_q.size()), 32'(PROG_DEPTH));
        for (int k = 0; k < wr_q.size() && k < int'(PROG_DEPTH); k++)
            check($sformatf("l1_wr%0d", k), 32'(wr_q[k]), 32'({4'(k), 4'(k), 4'd0}));

        // Randomly gapped load started from HALT
        wr_q.delete();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        check("l2_enter_state", 32'(bus.state), 32'(ST_LOAD));
        check("l2_enter_rstn", 32'(bus.cpu_rst_n), 32'd0);
        check("l2_enter_ready", 32'(bus.load_ready), 32'd1);
        sent = 0;
        for (int cyc = 0; cyc < 300 && sent < int'(PROG_DEPTH); cyc++) begin
            if ($urandom_range(0, 2) == 0) begin
                bus.load_valid = 1'b0;
                bus.load_data  = 8'hA5;
            end else begin
                bus.load_valid = 1'b1;
                bus.load_data  = {4'(~sent), 4'(sent)};
            end
            acc = bus.load_valid && bus.load_ready;
            tick();
            if (acc) sent++;
        end
        bus.load_valid = 1'b0;
        check("l2_sent", 32'(sent), 32'(PROG_DEPTH));
        for (int i = 0; i < 10 && bus.state != ST_HALT; i++) tick();
        check("l2_halt_state", 32'(bus.state), 32'(ST_HALT));
        check("l2_wr_count", 32'(wr_q.size()), 32'(PROG_DEPTH));
        for (int k = 0; k < wr_q.size() && k < int'(PROG_DEPTH); k++)
            check($sformatf("l2_wr%0d", k), 32'(wr_q[k]), 32'({4'(k), 4'(k), 4'(~k)}));
        check("loads_no_en", 32'(en_count), 32'd0);

        // Free run for ten cycles, then halt
        tick();
        tick();
        en_count = 0;
        bus.cmd_run = 1'b1;
        tick();
        bus.cmd_run = 1'b0;
        check("run_state", 32'(bus.state), 32'(ST_RUN));
        check("run_en_first", 32'(bus.cpu_en), 32'd1);
        repeat (9) tick();
        check("run_en_tenth", 32'(bus.cpu_en), 32'd1);
        bus.cmd_halt = 1'b1;
        tick();
        bus.cmd_halt = 1'b0;
        check("halt_en", 32'(bus.cpu_en), 32'd0);
        check("halt_state", 32'(bus.state), 32'(ST_HALT));
        check("run_en_cycles", 32'(en_count), 32'd10);

        // Command table from HALT
        en_count = 0;
        for (int i = 0; i < NVEC; i++) begin
            bus.load_start = vecs[i].ls;
            bus.cmd_run    = vecs[i].run;
            bus.cmd_step   = vecs[i].step;
            bus.cmd_halt   = vecs[i].halt;
            tick();
            bus.load_start = 1'b0;
            bus.cmd_run    = 1'b0;
            bus.cmd_step   = 1'b0;
            bus.cmd_halt   = 1'b0;
            check($sformatf("v%0d_state", i), 32'(bus.state), 32'(vecs[i].st));
            check($sformatf("v%0d_en", i), 32'(bus.cpu_en), 32'(vecs[i].en));
            check($sformatf("v%0d_rstn", i), 32'(bus.cpu_rst_n), 32'(vecs[i].rstn));
            check($sformatf("v%0d_ready", i), 32'(bus.load_ready), 32'(vecs[i].rdy));
            check($sformatf("v%0d_we", i), 32'(bus.mem_we), 32'd0);
            if (i == 3) check("step_en_cycles", 32'(en_count), 32'(STEP_CYCLES));
        end

        // Asynchronous reset while byte 7 of a load is on the bus
        wr_q.delete();
        for (int k = 0; k < 7; k++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 8'(k);
            tick();
        end
        bus.load_data = 8'h07;
        #6;
        rst_n = 1'b0;
        #1;
        check_reset("arst");
        bus.load_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_idle_state", 32'(bus.state), 32'(ST_IDLE));
        check("arst_idle_we", 32'(bus.mem_we), 32'd0);
        check("arst_idle_ready", 32'(bus.load_ready), 32'd0);
        check("arst_wr_count", 32'(wr_q.size()), 32'd7);

        // Run straight from IDLE releases the CPU reset on the same edge
        bus.cmd_run = 1'b1;
        tick();
        bus.cmd_run = 1'b0;
        check("idle_run_state", 32'(bus.state), 32'(ST_RUN));
        check("idle_run_rstn", 32'(bus.cpu_rst_n), 32'd1);
        check("idle_run_en", 32'(bus.cpu_en), 32'd1);
        bus.cmd_halt = 1'b1;
        tick();
        bus.cmd_halt = 1'b0;
        check("idle_run_halt", 32'(bus.state), 32'(ST_HALT));
        check("idle_run_halt_en", 32'(bus.cpu_en), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
